// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory-access stage: MMIO map, FSM states
// and the read-abort fill value.
package lc3_mem_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    localparam logic [15:0] ERR_DATA_DEFAULT = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT
    } state_e;

    // Only the four exact device addresses are I/O; everything else is SRAM.
    function automatic logic is_mmio(input logic [15:0] addr);
        return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
               (addr == DSR_ADDR)  || (addr == DDR_ADDR);
    endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 keyboard/display device registers (KBSR, KBDR, DSR, DDR) and the
// one-cycle display strobe.
module lc3_mmio_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en_i,
    input  logic        wr_en_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    input  logic        kb_valid_i,
    input  logic [7:0]  kb_data_i,
    input  logic        disp_ready_i,
    output logic [15:0] rdata_o,
    output logic        disp_valid_o,
    output logic [7:0]  disp_data_o
);

    logic       kbsr_q, kbsr_d;
    logic [7:0] kbdr_q, kbdr_d;
    logic       dsr_q, dsr_d;
    logic       disp_valid_q, disp_valid_d;
    logic [7:0] disp_data_q, disp_data_d;

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        kbsr_d       = kbsr_q;
        kbdr_d       = kbdr_q;
        dsr_d        = dsr_q;
        disp_valid_d = 1'b0;
        disp_data_d  = disp_data_q;

        if (rd_en_i && addr_i == KBDR_ADDR)
            kbsr_d = 1'b0;
        // A fresh keystroke wins over a coincident KBDR read.
        if (kb_valid_i) begin
            kbdr_d = kb_data_i;
            kbsr_d = 1'b1;
        end

        if (!dsr_q && disp_ready_i)
            dsr_d = 1'b1;
        if (wr_en_i && addr_i == DDR_ADDR && dsr_q) begin
            disp_data_d  = wdata_i;
            disp_valid_d = 1'b1;
            dsr_d        = 1'b0;
        end
    end

    // NOTE: sequential state uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            kbsr_q       <= 1'b0;
            kbdr_q       <= '0;
            dsr_q        <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            kbsr_q       <= kbsr_d;
            kbdr_q       <= kbdr_d;
            dsr_q        <= dsr_d;
            disp_valid_q <= disp_valid_d;
            disp_data_q  <= disp_data_d;
        end
    end

    always_comb begin
        unique case (addr_i)
            KBSR_ADDR: rdata_o = {kbsr_q, 15'b0};
            KBDR_ADDR: rdata_o = {8'b0, kbdr_q};
            DSR_ADDR:  rdata_o = {dsr_q, 15'b0};
            DDR_ADDR:  rdata_o = {8'b0, disp_data_q};
            default:   rdata_o = '0;
        endcase
    end

    assign disp_valid_o = disp_valid_q;
    assign disp_data_o  = disp_data_q;

endmodule

// File: rtl/lc3_mem_unit.sv
// LC-3 memory-access stage: MAR/MDR, SRAM request/ack handshake with timeout,
// and MMIO decode into the device register block.
module lc3_mem_unit
    import lc3_mem_pkg::*;
#(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter int              TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       Buss,
    input  logic              ldMAR,
    input  logic              ldMDR,
    input  logic              selMDR,
    input  logic              memWE,
    output logic [15:0]       mdrOut,
    output logic              memBusy,
    output logic              memErr,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    input  logic              sram_ack,
    input  logic              kb_valid,
    input  logic [7:0]        kb_data,
    output logic              disp_valid,
    output logic [7:0]        disp_data,
    input  logic              disp_ready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic        mmio_rd, mmio_wr, mar_is_mmio;
    logic [15:0] mar16, mmio_rdata;

    assign mar16       = 16'(mar_q);
    assign mar_is_mmio = is_mmio(mar16);

    lc3_mmio_regs u_mmio (
        .clk          (clk),
        .rst          (rst),
        .rd_en_i      (mmio_rd),
        .wr_en_i      (mmio_wr),
        .addr_i       (mar16),
        .wdata_i      (mdr_q[7:0]),
        .kb_valid_i   (kb_valid),
        .kb_data_i    (kb_data),
        .disp_ready_i (disp_ready),
        .rdata_o      (mmio_rdata),
        .disp_valid_o (disp_valid),
        .disp_data_o  (disp_data)
    );

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mmio_rd = 1'b0;
        mmio_wr = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Commands are prioritised memWE > ldMDR > ldMAR; losers are dropped.
                if (memWE) begin
                    if (mar_is_mmio) begin
                        mmio_wr = 1'b1;
                    end else begin
                        state_d = WR_WAIT;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = mar_q;
                        wdata_d = mdr_q;
                        cnt_d   = '0;
                    end
                end else if (ldMDR) begin
                    if (!selMDR) begin
                        mdr_d = DATA_W'(Buss);
                    end else if (mar_is_mmio) begin
                        mmio_rd = 1'b1;
                        mdr_d   = DATA_W'(mmio_rdata);
                    end else begin
                        state_d = RD_WAIT;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = mar_q;
                        cnt_d   = '0;
                    end
                end else if (ldMAR) begin
                    mar_d = ADDR_W'(Buss);
                end
            end
            RD_WAIT, WR_WAIT: begin
                // An ack in the final allowed cycle still completes normally.
                if (sram_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (state_q == RD_WAIT)
                        mdr_d = sram_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    if (state_q == RD_WAIT)
                        mdr_d = ERR_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mdrOut     = 16'(mdr_q);
    assign memBusy    = (state_q != IDLE);
    assign memErr     = err_q;
    assign sram_req   = req_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Self-checking bench for lc3_mem_unit: MMIO vector table, hand-written
// handshake corner cases and randomized SRAM traffic against a memory model.
module tb_lc3_mem_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] Buss = '0;
    logic        ldMAR = 0, ldMDR = 0, selMDR = 0, memWE = 0;
    logic [15:0] mdrOut;
    logic        memBusy, memErr, sram_req, sram_we;
    logic [15:0] sram_addr, sram_wdata;
    logic [15:0] sram_rdata = '0;
    logic        sram_ack = 0;
    logic        kb_valid = 0;
    logic [7:0]  kb_data = '0;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready = 0;

    lc3_mem_unit dut (
        .clk(clk), .rst(rst), .Buss(Buss), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .selMDR(selMDR), .memWE(memWE), .mdrOut(mdrOut), .memBusy(memBusy),
        .memErr(memErr), .sram_req(sram_req), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ack(sram_ack), .kb_valid(kb_valid), .kb_data(kb_data),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready)
    );

    always #5 clk = ~clk;

    localparam int TIMEOUT = 15;

    int n_checks = 0;
    int n_pass   = 0;

    // SRAM contents as seen by the environment, and the expected memory image.
    bit [15:0] env_mem   [bit [15:0]];
    bit [15:0] model_mem [bit [15:0]];

    typedef enum {OP_RD, OP_KB, OP_WR, OP_RDY, OP_BUSS} op_e;
    typedef struct {
        op_e         op;
        logic [15:0] arg;
        logic [15:0] exp_mdr;
        logic        exp_dv;
        logic [7:0]  exp_dd;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(input logic [15:0] a);
        Buss = a; ldMAR = 1; cycle(); ldMAR = 0;
    endtask

    task automatic load_mdr(input logic [15:0] d);
        Buss = d; ldMDR = 1; selMDR = 0; cycle(); ldMDR = 0;
    endtask

    task automatic mmio_read(input logic [15:0] a);
        load_mar(a);
        ldMDR = 1; selMDR = 1; cycle(); ldMDR = 0; selMDR = 0;
    endtask

    function automatic logic [15:0] env_read(input logic [15:0] a);
        return env_mem.exists(a) ? env_mem[a] : 16'h0;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        return model_mem.exists(a) ? model_mem[a] : 16'h0;
    endfunction

    // One SRAM access; waits < 0 means the SRAM never acknowledges.
    task automatic sram_access(input bit is_write, input bit do_load, input logic [15:0] addr,
                               input logic [15:0] data, input int waits, output int busy);
        int exp_busy;
        if (do_load) load_mar(addr);
        if (is_write) load_mdr(data);
        if (is_write) memWE = 1;
        else begin ldMDR = 1; selMDR = 1; end
        cycle();
        memWE = 0; ldMDR = 0; selMDR = 0;
        busy = 0;
        while (memBusy && busy < 40) begin
            busy++;
            if (busy == 1) begin
                check("req_high", sram_req, 1);
                check("req_we", sram_we, is_write);
                check("req_addr", sram_addr, addr);
                if (is_write) check("req_wdata", sram_wdata, data);
            end
            if (busy == waits + 1) begin
                sram_ack = 1;
                if (is_write) env_mem[sram_addr] = sram_wdata;
                else sram_rdata = env_read(sram_addr);
            end
            cycle();
            sram_ack = 0;
            sram_rdata = 16'($urandom);
        end
        exp_busy = (waits < 0) ? TIMEOUT : waits + 1;
        check("busy_cycles", busy, exp_busy);
        check("req_dropped", sram_req, 0);
    endtask

    initial begin
        int busy;

        // Reset state
        repeat (3) cycle();
        check("rst_mdr", mdrOut, 0);
        check("rst_busy", memBusy, 0);
        check("rst_err", memErr, 0);
        check("rst_req", sram_req, 0);
        check("rst_dv", disp_valid, 0);
        check("rst_dd", disp_data, 0);
        rst = 1;
        cycle();

        // MMIO vector table
        vecs.push_back('{OP_RD,   16'hFE00, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{OP_RD,   16'hFE04, 16'h8000, 1'b0, 8'h00});
        vecs.push_back('{OP_RD,   16'hFE02, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{OP_KB,   16'h0041, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{OP_RD,   16'hFE00, 16'h8000, 1'b0, 8'h00});
        vecs.push_back('{OP_RD,   16'hFE02, 16'h0041, 1'b0, 8'h00});
        vecs.push_back('{OP_RD,   16'hFE00, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{OP_WR,   16'h0048, 16'h0000, 1'b1, 8'h48});
        vecs.push_back('{OP_RD,   16'hFE04, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{OP_WR,   16'h0055, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{OP_RDY,  16'h0000, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{OP_RD,   16'hFE04, 16'h8000, 1'b0, 8'h00});
        vecs.push_back('{OP_KB,   16'h007A, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{OP_KB,   16'h0033, 16'h0000, 1'b0, 8'h00});
        vecs.push_back('{OP_RD,   16'hFE02, 16'h0033, 1'b0, 8'h00});
        vecs.push_back('{OP_BUSS, 16'h1357, 16'h1357, 1'b0, 8'h00});

        foreach (vecs[i]) begin
            unique case (vecs[i].op)
                OP_RD: begin
                    mmio_read(vecs[i].arg);
                    check($sformatf("vec%0d_mdr", i), mdrOut, vecs[i].exp_mdr);
                    check($sformatf("vec%0d_busy", i), memBusy, 0);
                end
                OP_KB: begin
                    kb_valid = 1; kb_data = vecs[i].arg[7:0]; cycle(); kb_valid = 0;
                end
                OP_WR: begin
                    load_mar(16'hFE06);
                    load_mdr(vecs[i].arg);
                    memWE = 1; cycle(); memWE = 0;
                    check($sformatf("vec%0d_dv", i), disp_valid, vecs[i].exp_dv);
                    if (vecs[i].exp_dv) check($sformatf("vec%0d_dd", i), disp_data, vecs[i].exp_dd);
                    cycle();
                    check($sformatf("vec%0d_dv_end", i), disp_valid, 0);
                end
                OP_RDY: begin
                    disp_ready = 1; cycle(); disp_ready = 0;
                end
                OP_BUSS: begin
                    load_mdr(vecs[i].arg);
                    check($sformatf("vec%0d_mdr", i), mdrOut, vecs[i].exp_mdr);
                end
                default: ;
            endcase
        end

        // Keystroke coincident with a KBDR read: new byte wins
        load_mar(16'hFE02);
        ldMDR = 1; selMDR = 1; kb_valid = 1; kb_data = 8'h99; cycle();
        ldMDR = 0; selMDR = 0; kb_valid = 0;
        mmio_read(16'hFE00);
        check("kb_coincide_kbsr", mdrOut, 16'h8000);
        mmio_read(16'hFE02);
        check("kb_coincide_kbdr", mdrOut, 16'h0099);

        // SRAM read with 3 wait states
        env_mem[16'h3000] = 16'h1234;
        sram_access(0, 1, 16'h3000, 16'h0, 3, busy);
        check("rd3_mdr", mdrOut, 16'h1234);

        // SRAM write with 1 wait state
        sram_access(1, 1, 16'h4000, 16'hABCD, 1, busy);
        check("wr1_err", memErr, 0);
        check("wr1_mem", env_read(16'h4000), 16'hABCD);

        // memWE beats ldMDR and ldMAR in the same cycle
        load_mar(16'h4100);
        load_mdr(16'h1111);
        memWE = 1; ldMDR = 1; selMDR = 0; ldMAR = 1; Buss = 16'h2222; cycle();
        memWE = 0; ldMDR = 0; ldMAR = 0;
        check("prio_we", sram_we, 1);
        check("prio_addr", sram_addr, 16'h4100);
        check("prio_wdata", sram_wdata, 16'h1111);
        sram_ack = 1; cycle(); sram_ack = 0;
        check("prio_mdr", mdrOut, 16'h1111);
        check("prio_idle", memBusy, 0);

        // ldMDR beats ldMAR
        load_mar(16'h4200);
        ldMDR = 1; selMDR = 0; ldMAR = 1; Buss = 16'h7777; cycle();
        ldMDR = 0; ldMAR = 0;
        check("prio2_mdr", mdrOut, 16'h7777);
        sram_access(0, 0, 16'h4200, 16'h0, 0, busy);

        // Commands while busy are ignored
        load_mar(16'h3000);
        ldMDR = 1; selMDR = 1; cycle();
        ldMDR = 1; selMDR = 0; ldMAR = 1; memWE = 1; Buss = 16'hAAAA;
        cycle(); cycle();
        ldMDR = 0; ldMAR = 0; memWE = 0;
        check("ign_we", sram_we, 0);
        sram_ack = 1; sram_rdata = 16'h1234; cycle(); sram_ack = 0;
        check("ign_mdr", mdrOut, 16'h1234);
        check("ign_idle", memBusy, 0);
        sram_access(0, 0, 16'h3000, 16'h0, 0, busy);

        // Ack in the final allowed cycle is a success
        env_mem[16'h3100] = 16'h0F0F;
        sram_access(0, 1, 16'h3100, 16'h0, TIMEOUT - 1, busy);
        check("late_ack_mdr", mdrOut, 16'h0F0F);
        check("late_ack_err", memErr, 0);

        // Randomized SRAM traffic against the memory model
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a, d;
            bit          w;
            int          waits;
            a     = 16'h6000 + 16'($urandom_range(0, 7));
            d     = 16'($urandom);
            w     = 1'($urandom);
            waits = $urandom_range(0, 6);
            if (w) begin
                sram_access(1, 1, a, d, waits, busy);
                model_mem[a] = d;
            end else begin
                sram_access(0, 1, a, 16'h0, waits, busy);
                check("rand_rd", mdrOut, model_read(a));
            end
        end
        check("rand_err", memErr, 0);

        // Read timeout
        sram_access(0, 1, 16'h5000, 16'h0, -1, busy);
        check("to_mdr", mdrOut, 16'hDEAD);
        check("to_err", memErr, 1);
        check("to_busy", memBusy, 0);
        sram_access(1, 1, 16'h4300, 16'h5A5A, 0, busy);
        check("to_err_sticky", memErr, 1);
        load_mdr(16'hDEAD);

        // Reset during a read
        load_mar(16'h5100);
        ldMDR = 1; selMDR = 1; cycle(); ldMDR = 0; selMDR = 0;
        check("mid_busy", memBusy, 1);
        cycle();
        rst = 0; cycle();
        check("mid_req", sram_req, 0);
        check("mid_mdr", mdrOut, 0);
        check("mid_busy_rst", memBusy, 0);
        check("mid_err", memErr, 0);
        rst = 1;
        sram_ack = 1; sram_rdata = 16'hBEEF; cycle(); sram_ack = 0;
        check("late_mdr", mdrOut, 0);
        check("late_busy", memBusy, 0);
        check("late_req", sram_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lc3_mem_unit.md
Name: lc3_mem_unit

Overview:
- Memory-access stage between the LC-3 datapath/controller and storage; consumed by the datapath's MDR bus driver, fed by Buss.
- Holds MAR and MDR and runs a handshake FSM to an external wait-stated SRAM.
- Decodes LC-3 memory-mapped I/O registers: KBSR, KBDR, DSR, DDR.
- Asserts memBusy so the controller can stall while an access is outstanding.

Parameters:
- ADDR_W, 16, address width of MAR and SRAM port.
- DATA_W, 16, data width of MDR and SRAM.
- TIMEOUT, 15, maximum cycles to wait for sram_ack before an access is aborted.
- ERR_DATA, 16'hDEAD, value loaded into MDR on a read timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: synchronous, active-low.
- Buss  in  16  datapath bus.
- ldMAR  in  1  MAR <= Buss.
- ldMDR  in  1  load MDR: source chosen by selMDR.
- selMDR  in  1  0 = from Buss, 1 = from memory read.
- memWE  in  1  write MDR to Mem[MAR].
- mdrOut  out  16  MDR contents, to the bus driver.
- memBusy  out  1  access in flight; controller holds state while high.
- memErr  out  1  sticky timeout flag; cleared only by reset.
- sram_req  out  1  request, held until ack.
- sram_we  out  1  1 = write request.
- sram_addr  out  16  request address.
- sram_wdata  out  16  write data.
- sram_rdata  in  16  read data, valid with ack.
- sram_ack  in  1  one-cycle completion.
- kb_valid  in  1  keyboard byte strobe.
- kb_data  in  8  keyboard byte.
- disp_valid  out  1  one-cycle display strobe.
- disp_data  out  8  display byte.
- disp_ready  in  1  display can accept.

Behaviour:
- Reset (rst=0 at posedge): MAR=0, MDR=0, state=IDLE, all outputs 0, KBSR=0, KBDR=0, DSR[15]=1.
- MMIO map:
  - FE00 = KBSR; bit 15 is ready.
  - FE02 = KBDR; low 8 bits are data.
  - FE04 = DSR; bit 15 is ready.
  - FE06 = DDR.
  - All other addresses go to SRAM.
- Accesses are recognised only in IDLE; ldMAR/ldMDR/memWE are ignored while memBusy=1.
- IDLE is the only state that accepts new commands.
- ldMAR in IDLE: MAR <= Buss the next edge.
- ldMDR & !selMDR: MDR <= Buss, single cycle.
- ldMDR & selMDR to MMIO: MDR <= register value zero-extended, single cycle, memBusy stays 0.
  - Reading KBDR clears KBSR[15].
- ldMDR & selMDR to SRAM: go to RD_WAIT.
  - sram_req=1, sram_we=0, sram_addr=MAR, memBusy=1.
  - On sram_ack: MDR <= sram_rdata, then IDLE.
  - Latency is 1 + wait cycles.
- memWE to MMIO DDR, only if DSR[15]=1:
  - disp_data=MDR[7:0] and disp_valid pulse next cycle; DSR[15] <= 0.
  - DSR[15] returns to 1 on the first cycle disp_ready=1.
  - Write to DDR with DSR[15]=0 is dropped.
  - Writes to KBSR, KBDR, DSR are ignored.
- memWE to SRAM: WR_WAIT.
  - sram_req=1, sram_we=1, sram_wdata=MDR, memBusy=1 until ack.
- Simultaneous commands: memWE > ldMDR > ldMAR priority; lower-priority commands in the same cycle are dropped.
- Timeout counter:
  - Clears on entry to RD_WAIT/WR_WAIT and increments each waiting cycle.
  - At TIMEOUT without ack: drop sram_req, set memErr.
  - A read abort loads MDR=ERR_DATA; return to IDLE.
- Ack arriving in the same cycle the count hits TIMEOUT counts as success.
- kb_valid: KBDR <= kb_data and KBSR[15] <= 1.
  - Overwrites any unread byte.
  - If coincident with a KBDR read, the new byte wins and KBSR[15]=1.
- Reset mid-access: sram_req drops at that edge and the transaction is abandoned.
- Register outputs: sram_* and disp_* are driven from flops, not combinationally from inputs.

Decomposition:
- Package lc3_mem_pkg:
  - MMIO address constants (KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR).
  - State enum {IDLE, RD_WAIT, WR_WAIT}.
  - ERR_DATA default.
- One sub-module, lc3_mmio_regs, holds KBSR/KBDR/DSR/DDR and the display strobe logic. The handshake FSM and MAR/MDR stay in the top.

Test Plan:
- SRAM read with 3 wait states: MAR=3000, read with sram_rdata=1234 acked on cycle 4 -> memBusy high 4 cycles, mdrOut=1234, sram_addr=3000.
- SRAM write: MAR=4000, MDR=ABCD, memWE, ack after 1 wait -> sram_we=1, sram_wdata=ABCD, memBusy 2 cycles, memErr=0.
- Keyboard: kb_valid with 0x41, then read FE00 -> MDR=8000. Read FE02 -> MDR=0041. Read FE00 again -> 0000.
- Display: write 0x0048 to FE06 -> disp_valid one cycle with disp_data=48, DSR reads 0000. Second write is dropped. Assert disp_ready -> DSR reads 8000.
- Timeout: read 5000 with no ack -> after 15 waiting cycles sram_req=0, mdrOut=DEAD, memErr=1, memBusy=0.
- Reset mid-read: rst=0 during RD_WAIT -> next edge sram_req=0, mdrOut=0, state IDLE. A late ack after reset changes nothing.
